// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction memory with startup delay, fixed fetch latency and flush
module imem_responder #(
  parameter int          DEPTH_LOG2     = 10,
  parameter int          LATENCY        = 2,
  parameter int          STARTUP_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);
  typedef enum logic [1:0] {STARTUP, IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] START_CNT = 4'(STARTUP_CYCLES - 1);
  localparam logic [3:0] WAIT_CNT  = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [29:0] word_off;
  logic        addr_err, accept;
  // BASE_ADDR is word aligned, so the word offset is a 30-bit difference
  assign word_off  = req_addr[31:2] - BASE_ADDR[31:2];
  assign addr_err  = (|req_addr[1:0]) | (req_addr < BASE_ADDR) | (|word_off[29:DEPTH_LOG2]);
  assign req_ready = state_q == IDLE || state_q == RESP;
  assign accept    = req_valid & req_ready & ~flush;
  assign rsp_valid = state_q == RESP && !flush;
  assign rsp_err   = state_q == RESP && err_q;
  assign rsp_data  = state_q == RESP ? data_q : NOP_INSTR;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      STARTUP: begin
        state_d = cnt_q == 4'd0 ? IDLE : STARTUP;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      WAIT: begin
        state_d = flush ? IDLE : cnt_q == 4'd0 ? RESP : WAIT;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      data_d  = addr_err ? NOP_INSTR : mem[word_off[DEPTH_LOG2-1:0]];
      err_d   = addr_err;
      state_d = LATENCY == 1 ? RESP : WAIT;
      cnt_d   = WAIT_CNT;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STARTUP;
      cnt_q   <= START_CNT;
      data_q  <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and random fetch traffic against a cycle-indexed reference model
module tb_imem_responder;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int L = 2;
  localparam int S = 4;
  logic clk = 0, rst_n = 0, req_valid = 0, flush = 0, ld_en = 0;
  logic [31:0] req_addr = 0, ld_data = 0;
  logic [9:0] ld_addr = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  imem_responder #(.DEPTH_LOG2(10), .LATENCY(L), .STARTUP_CYCLES(S), .BASE_ADDR(BASE), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, ready_from = 0, resp_cyc = 0, pulses = 0;
  bit known = 0, pend = 0, perr = 0;
  logic [31:0] pdata, last_data;
  logic last_err;
  logic [31:0] mm [1024];
  logic [31:0] init_val [16];
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic tick(bit rn, bit rv, logic [31:0] a, bit fl, bit le = 0, logic [9:0] la = 0, logic [31:0] ld = 0);
    bit er, rs, ev, acc, aerr;
    logic [31:0] ix;
    rst_n = rn; req_valid = rv; req_addr = a; flush = fl; ld_en = le; ld_addr = la; ld_data = ld;
    @(negedge clk);
    if (known) begin
      er = cyc >= ready_from;
      rs = pend && resp_cyc == cyc;
      ev = rs && !fl;
      chk("ready", 32'(req_ready), 32'(er));
      chk("valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("data", rsp_data, pdata);
        chk("err", 32'(rsp_err), 32'(perr));
      end else if (!rs) begin
        chk("idle_data", rsp_data, NOP);
        chk("idle_err", 32'(rsp_err), 32'd0);
      end
      if (rsp_valid) begin
        pulses++;
        last_data = rsp_data;
        last_err = rsp_err;
      end
    end
    @(posedge clk);
    if (!rn) begin
      known = 1;
      pend = 0;
      ready_from = cyc + 1 + S;
    end else if (known) begin
      acc = rv && cyc >= ready_from && !fl;
      if (pend && resp_cyc <= cyc) pend = 0;
      if (fl && pend) begin
        pend = 0;
        ready_from = cyc + 1;
      end
      if (acc) begin
        ix = (a - BASE) >> 2;
        aerr = a[1:0] != 2'b00 || a < BASE || ix >= 32'd1024;
        perr = aerr;
        pdata = aerr ? NOP : mm[ix[9:0]];
        pend = 1;
        resp_cyc = cyc + L;
        ready_from = cyc + L;
      end
    end
    if (le) mm[la] = ld;
    cyc++;
    #1;
  endtask
  initial begin
    logic [31:0] errs [3];
    int p0, r;
    logic [31:0] a;
    errs[0] = 32'h0040_0002; errs[1] = 32'h003F_FFFC; errs[2] = 32'h0040_1000;
    for (int i = 0; i < 16; i++) init_val[i] = (i == 3) ? 32'h00A0_0093 : $urandom;
    for (int i = 0; i < 16; i++) tick(0, 0, 0, 0, 1, 10'(i), init_val[i]);
    tick(0, 0, 0, 0, 1, 10'd1023, 32'hCAFE_F00D);
    for (int i = 0; i < S + 1; i++) tick(1, 1, BASE + 32'hC, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    chk("single_pulses", pulses, 1);
    chk("single_data", last_data, 32'h00A0_0093);
    chk("single_err", 32'(last_err), 0);
    pulses = 0;
    tick(1, 1, BASE, 0);
    tick(1, 1, BASE + 4, 0);
    tick(1, 1, BASE + 4, 0);
    tick(1, 1, BASE + 8, 0);
    tick(1, 1, BASE + 8, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    chk("b2b_pulses", pulses, 3);
    chk("b2b_last", last_data, init_val[2]);
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, errs[k], 0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("errcase_err", 32'(last_err), 1);
      chk("errcase_data", last_data, NOP);
    end
    p0 = pulses;
    tick(1, 1, BASE + 4, 0);
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 0);
    tick(1, 1, BASE, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    chk("flush_nopulse", pulses, p0);
    tick(1, 1, BASE + 8, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < S + 2; i++) tick(1, 0, 0, 0);
    chk("reset_nopulse", pulses, p0);
    tick(1, 1, BASE + 20, 0, 1, 10'd5, 32'h1234_5678);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("collide_old", last_data, init_val[5]);
    tick(1, 1, BASE + 20, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("collide_new", last_data, 32'h1234_5678);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      a = r < 8 ? BASE + 4 * $urandom_range(0, 15) :
          r == 8 ? ($urandom_range(0, 1) ? BASE + 32'hFFC : BASE + 32'h1000) :
          ($urandom_range(0, 1) ? BASE - 4 : BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3)));
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, a, $urandom_range(0, 11) == 0,
           $urandom_range(0, 5) == 0, 10'($urandom_range(0, 15)), $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the core's fetch-side memory FSM (STARTUP/IDLE/MEMREAD/RESTART) over a valid/ready request and pulsed response interface.
- Holds a word-addressed instruction array with a bench-side preload port.
- Models a configurable startup delay and fixed access latency.
- Supports a flush input so the core can abandon an in-flight fetch on branch/jump restart.

Parameters:
- DEPTH_LOG2, 10, log2 of array depth in 32-bit words.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.
- STARTUP_CYCLES, 4, cycles after reset release before the first request may be accepted; legal range 1..15.
- BASE_ADDR, 32'h0040_0000, byte address of word 0.
- NOP_INSTR, 32'h0000_0013, data returned on error or when idle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset.
- req_valid  in  1  fetch request.
- req_addr  in  32  byte address of the fetch.
- req_ready  out  1  responder can accept a request this cycle.
- flush  in  1  abandon any in-flight fetch.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  fetched instruction.
- rsp_err  out  1  address misaligned or out of range; qualified by rsp_valid.
- ld_en  in  1  preload write enable.
- ld_addr  in  DEPTH_LOG2  preload word index.
- ld_data  in  32  preload data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=STARTUP, counter=STARTUP_CYCLES-1, req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=NOP_INSTR. The array is not cleared.
- States: STARTUP, IDLE, WAIT, RESP.
- STARTUP:
  - req_ready=0.
  - Counter decrements each cycle; at 0, go to IDLE.
  - req_ready first goes high exactly STARTUP_CYCLES cycles after the first cycle with rst_n=1.
  - flush has no effect in STARTUP.
- Accept condition: req_valid & req_ready & ~flush, sampled at a rising edge. req_ready is 1 in IDLE and RESP, 0 in STARTUP and WAIT. It is not gated by flush.
- On accept:
  - The array is read at the accepting edge; data and error flag are registered.
  - If LATENCY=1, go to RESP. Otherwise go to WAIT with counter=LATENCY-2.
- WAIT: counter decrements; at 0, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_data and rsp_err hold the registered values.
  - This occurs LATENCY cycles after the accepting edge.
  - If a new request is accepted at the edge ending RESP, move to WAIT/RESP per LATENCY. Otherwise go to IDLE.
  - Sustained throughput is one fetch per LATENCY cycles.
- Outside RESP: rsp_valid=0, rsp_err=0, rsp_data=NOP_INSTR.
- Address check:
  - Index = (req_addr-BASE_ADDR)>>2.
  - Error if req_addr[1:0]!=0, req_addr<BASE_ADDR, or index >= 2^DEPTH_LOG2.
  - On error: rsp_err=1, rsp_data=NOP_INSTR, and the array is not read.
  - Subtraction is 32-bit unsigned; underflow is caught by the req_addr<BASE_ADDR compare.
- Flush:
  - flush=1 in WAIT or RESP suppresses the pending response: rsp_valid forced 0 that cycle, next state IDLE.
  - flush=1 with req_valid=1 blocks acceptance; flush wins.
- Preload:
  - ld_en writes mem[ld_addr] at the edge, in any state including STARTUP.
  - A load to the same index at the accepting edge returns the old data.
  - A load after acceptance does not alter the in-flight response.
- Reset asserted mid-operation: the in-flight fetch is dropped and the block returns to STARTUP with reset values at the next edge.

Test Plan:
- Startup timing: release reset at edge 0 with defaults -> req_ready=0 for 4 cycles, 1 from cycle 4. A req_valid held from edge 0 is accepted only at the first edge with req_ready=1.
- Single fetch: preload mem[3]=32'h00A00093, request 32'h0040_000C with LATENCY=2 -> rsp_valid high exactly 2 cycles after accept, rsp_data=32'h00A00093, rsp_err=0.
- Back-to-back fetches: req_valid held high at addresses 0x00400000, 0x00400004, 0x00400008 -> three rsp_valid pulses spaced 2 cycles apart, data in order.
- Error cases: addresses 0x00400002, 0x003FFFFC and 0x00401000 -> each gives rsp_err=1, rsp_data=32'h00000013.
- Flush: flush in the WAIT cycle -> no rsp_valid, req_ready=1 next cycle. flush together with req_valid -> no accept.
- Reset and preload collision: drop rst_n during WAIT -> no response, STARTUP sequence repeats. ld_en to index 5 at the same edge as accepting 0x00400014 -> old mem[5] returned; the next fetch of that address returns the new value.
